// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR = 10;

  localparam logic [7:0] RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for key-schedule round r (1..NR); zero outside that range.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = RCON[1];
      4'd2:    v = RCON[2];
      4'd3:    v = RCON[3];
      4'd4:    v = RCON[4];
      4'd5:    v = RCON[5];
      4'd6:    v = RCON[6];
      4'd7:    v = RCON[7];
      4'd8:    v = RCON[8];
      4'd9:    v = RCON[9];
      4'd10:   v = RCON[10];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One AES encryption round plus the matching key-schedule step.
// Byte i of a 128-bit word is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  input  logic         last_round,
  output logic [127:0] st_next,
  output logic [127:0] rk_next
);

  logic [7:0]  sb    [16];
  logic [7:0]  sr    [16];
  logic [7:0]  mx    [16];
  logic [7:0]  ks    [4];
  logic [7:0]  kin   [4];
  logic [31:0] w0, w1, w2, w3;

  // SubBytes on every state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sb[i]));
  end

  // RotWord of the last key word feeds SubWord.
  assign kin[0] = rk[23:16];
  assign kin[1] = rk[15:8];
  assign kin[2] = rk[7:0];
  assign kin[3] = rk[31:24];

  for (genvar i = 0; i < 4; i++) begin : g_ksub
    aes_sbox u_sbox (.a(kin[i]), .y(ks[i]));
  end

  // Key expansion: each new word chains off the previous new word.
  always_comb begin
    w0      = rk[127:96] ^ {ks[0] ^ rcon, ks[1], ks[2], ks[3]};
    w1      = rk[95:64] ^ w0;
    w2      = rk[63:32] ^ w1;
    w3      = rk[31:0] ^ w2;
    rk_next = {w0, w1, w2, w3};
  end

  // ShiftRows: row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
    end
  end

  // MixColumns with the {02,03,01,01} circulant.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mx[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mx[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mx[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mx[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  // AddRoundKey; the final round skips MixColumns.
  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign st_next[127-8*i -: 8] = (last_round ? sr[i] : mx[i]) ^ rk_next[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, pure combinational table lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Table lookup; the 8-bit input indexes all 256 entries exactly.
  always_comb begin
    y = SBOX[a];
  end

endmodule

// File: rtl/aes_128_iter.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE rounds per clock,
// valid/ready on both sides, one block in flight.
module aes_128_iter
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
    $error("aes_128_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  localparam int unsigned ITER     = NR / ROUNDS_PER_CYCLE;
  localparam logic [3:0]  STEP     = 4'(ROUNDS_PER_CYCLE);
  // First round index of the iteration that finishes round NR.
  localparam logic [3:0]  LAST_RND = 4'(1 + (ITER - 1) * ROUNDS_PER_CYCLE);

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] cst  [ROUNDS_PER_CYCLE+1];
  logic [127:0] ckey [ROUNDS_PER_CYCLE+1];

  assign cst[0]  = st;
  assign ckey[0] = rk;

  // Unrolled round chain: unit j evaluates round rnd+j.
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [3:0] rnum;
    assign rnum = rnd + 4'(j);
    aes_round_unit u_round (
      .st        (cst[j]),
      .rk        (ckey[j]),
      .rcon      (rcon_of(rnum)),
      .last_round(rnum == 4'(NR)),
      .st_next   (cst[j+1]),
      .rk_next   (ckey[j+1])
    );
  end

  // In HOLD the sink handshake frees the core, so a new block can load on the same edge.
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign busy     = (state != IDLE);

  // Control FSM, round counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      st        <= '0;
      rk        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_state ^ in_key;
            rk    <= in_key;
            rnd   <= 4'd1;
            state <= RUN;
          end
        end
        RUN: begin
          st  <= cst[ROUNDS_PER_CYCLE];
          rk  <= ckey[ROUNDS_PER_CYCLE];
          rnd <= rnd + STEP;
          if (rnd == LAST_RND) begin
            out_data  <= cst[ROUNDS_PER_CYCLE];
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              st    <= in_state ^ in_key;
              rk    <= in_key;
              rnd   <= 4'd1;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_iter.sv
// Bench for aes_128_iter: all four legal ROUNDS_PER_CYCLE instances, each
// checked every cycle against a byte-level AES-128 reference model.
`timescale 1ns/1ps
module tb_aes_128_iter;

  localparam int NDUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [NDUT];
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_state  [NDUT];
  logic [127:0] in_key    [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_data  [NDUT];
  logic         busy      [NDUT];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned RPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes_128_iter #(.ROUNDS_PER_CYCLE(RPC)) dut (
      .clk(clk), .rst(rst[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_state(in_state[g]), .in_key(in_key[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_data(out_data[g]), .busy(busy[g])
    );
  end

  function automatic int iter_of(input int d);
    case (d)
      0: return 10;
      1: return 5;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: inverse (a^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = a; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [16];
    logic [7:0] tmp [4];
    logic [7:0] a [4];
    logic [7:0] rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      tmp[0] = sbox(k[13]) ^ rc; tmp[1] = sbox(k[14]);
      tmp[2] = sbox(k[15]);      tmp[3] = sbox(k[12]);
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          k[4*c+j] = k[4*c+j] ^ ((c == 0) ? tmp[j] : k[4*(c-1)+j]);
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[j+4*c] = t[j+4*((c+j)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03) ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- per-instance scoreboard ----------------
  bit           armed  [NDUT];
  bit           have   [NDUT];
  logic [127:0] exp_ct [NDUT];
  logic [127:0] last_ct[NDUT];
  int           due    [NDUT];
  int           xfer   [NDUT];

  // Track accepted blocks and completed transfers from model-predicted handshakes.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      bit ov;
      bit rdy;
      if (rst[d]) begin
        have[d] = 1'b0; last_ct[d] = '0; armed[d] = 1'b1;
      end else if (armed[d]) begin
        ov  = have[d] && (cyc - 1 >= due[d]);
        rdy = !have[d] || (ov && out_ready[d]);
        if (ov && out_ready[d]) begin
          have[d] = 1'b0; last_ct[d] = exp_ct[d]; xfer[d]++;
        end
        if (in_valid[d] && rdy) begin
          have[d] = 1'b1;
          exp_ct[d] = aes_ref(in_state[d], in_key[d]);
          due[d] = cyc + iter_of(d);
        end
      end
    end
  end

  // Compare every instance's outputs against the model each cycle.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      bit ov;
      if (armed[d]) begin
        ov = have[d] && (cyc >= due[d]);
        chk($sformatf("d%0d out_valid", d), 128'(out_valid[d]), 128'(ov));
        chk($sformatf("d%0d busy", d), 128'(busy[d]), 128'(have[d]));
        chk($sformatf("d%0d in_ready", d), 128'(in_ready[d]),
            128'(!have[d] || (ov && out_ready[d])));
        chk($sformatf("d%0d out_data", d), out_data[d], ov ? exp_ct[d] : last_ct[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] vs [5] = '{128'h00112233445566778899aabbccddeeff, 128'h0, 128'h0, 128'h1,
                           128'h3243f6a8885a308d313198a2e0370734};
  logic [127:0] vk [5] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 128'h1, 128'h0,
                           128'h2b7e151628aed2a6abf7158809cf4f3c};
  logic [127:0] vc [5] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                           128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                           128'h0545aad56da2a97c3663d1432a3d1c84,
                           128'h58e2fccefa7e3061367f1d57a4e7455a,
                           128'h3925841d02dc09fbdc118597196a0b32};

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] s, input logic [127:0] k, output int at);
    bit fire;
    in_state[d] = s; in_key[d] = k; in_valid[d] = 1'b1; at = -1;
    for (int t = 0; t < 64 && at < 0; t++) begin
      #1;
      fire = in_ready[d];
      tick();
      if (fire) at = cyc;
    end
    in_valid[d] = 1'b0;
    if (at < 0) chk($sformatf("d%0d accept timeout", d), 128'd0, 128'd1);
  endtask

  task automatic drain(input int d);
    int n;
    out_ready[d] = 1'b1;
    n = 0;
    while (have[d] && n < 64) begin tick(); n++; end
    if (have[d]) chk($sformatf("d%0d drain timeout", d), 128'd0, 128'd1);
  endtask

  task automatic wait_ov(input int d);
    int n;
    n = 0;
    while (!out_valid[d] && n < 40) begin tick(); n++; end
  endtask

  task automatic run_dut(input int d);
    int at, prev, x0, nblk, it;
    logic [127:0] hold_data;
    bit fire;
    it = iter_of(d);

    // State right after the initial reset.
    chk($sformatf("d%0d reset in_ready", d), 128'(in_ready[d]), 128'd1);
    chk($sformatf("d%0d reset out_valid", d), 128'(out_valid[d]), 128'd0);
    chk($sformatf("d%0d reset busy", d), 128'(busy[d]), 128'd0);
    chk($sformatf("d%0d reset out_data", d), out_data[d], 128'd0);

    // FIPS-197 vector with exact latency.
    out_ready[d] = 1'b1;
    send(d, vs[4], vk[4], at);
    wait_ov(d);
    chk($sformatf("d%0d fips latency", d), 128'(cyc - at), 128'(it));
    chk($sformatf("d%0d fips data", d), out_data[d], vc[4]);
    drain(d);

    // Back-to-back stream: one accept every ITER+1 edges.
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      send(d, vs[i], vk[i], at);
      if (i > 0) chk($sformatf("d%0d stream spacing %0d", d, i), 128'(at - prev), 128'(it + 1));
      prev = at;
    end
    drain(d);

    // Backpressure for seven cycles, then exactly one transfer.
    out_ready[d] = 1'b0;
    send(d, rnd128(), rnd128(), at);
    wait_ov(d);
    hold_data = out_data[d];
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("d%0d bp out_valid", d), 128'(out_valid[d]), 128'd1);
      chk($sformatf("d%0d bp out_data", d), out_data[d], hold_data);
      chk($sformatf("d%0d bp in_ready", d), 128'(in_ready[d]), 128'd0);
    end
    x0 = xfer[d];
    out_ready[d] = 1'b1;
    tick();
    tick();
    chk($sformatf("d%0d bp transfers", d), 128'(xfer[d] - x0), 128'd1);
    chk($sformatf("d%0d bp out_valid after", d), 128'(out_valid[d]), 128'd0);

    // Inputs change right after acceptance.
    send(d, rnd128(), rnd128(), at);
    in_state[d] = rnd128();
    in_key[d]   = rnd128();
    drain(d);

    // Reset during the third iteration discards the block.
    out_ready[d] = 1'b0;
    send(d, vs[4], vk[4], at);
    tick();
    tick();
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    chk($sformatf("d%0d rst in_ready", d), 128'(in_ready[d]), 128'd1);
    chk($sformatf("d%0d rst out_valid", d), 128'(out_valid[d]), 128'd0);
    chk($sformatf("d%0d rst out_data", d), out_data[d], 128'd0);
    chk($sformatf("d%0d rst busy", d), 128'(busy[d]), 128'd0);
    out_ready[d] = 1'b1;
    send(d, vs[0], vk[0], at);
    wait_ov(d);
    chk($sformatf("d%0d post-rst data", d), out_data[d], vc[0]);
    drain(d);

    // Random traffic with random sink stalls.
    nblk = 0;
    for (int t = 0; t < 400 && nblk < 6; t++) begin
      if (!in_valid[d] && ($urandom % 3 == 0)) begin
        in_state[d] = rnd128(); in_key[d] = rnd128(); in_valid[d] = 1'b1;
      end
      out_ready[d] = 1'($urandom % 2);
      #1;
      fire = in_valid[d] && in_ready[d];
      tick();
      if (fire) begin
        nblk++;
        in_valid[d] = 1'b0;
        in_state[d] = rnd128();
      end
    end
    in_valid[d] = 1'b0;
    drain(d);
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      in_state[d] = '0; in_key[d] = '0;
      armed[d] = 1'b0; have[d] = 1'b0; exp_ct[d] = '0; last_ct[d] = '0;
      due[d] = 0; xfer[d] = 0;
    end
    // Pin the reference model to published vectors.
    for (int i = 0; i < 5; i++)
      chk($sformatf("model vector %0d", i), aes_ref(vs[i], vk[i]), vc[i]);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    for (int d = 0; d < NDUT; d++) run_dut(d);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
